wb_pwm_bank: RTL and testbench
==============================

# wb_pwm_bank

Parametrised Wishbone-slave PWM timer bank: one shared prescaler and period counter driving `NUM_CH` PWM outputs. Duty and period registers are double-buffered; shadow values move to the active set only at period wrap, so updates are glitch-free. A sticky wrap flag can raise an interrupt. The block sits on the peripheral Wishbone bus beside the existing timer peripherals and drives pin-mux PWM inputs.

## Interface
- `NUM_CH`, 8, number of PWM channels (1..32)
- `CNT_W`, 16, period/duty/counter width in bits (2..32)
- `clk_i` in 1: single clock; every register is clocked on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `wb_cyc_i`, `wb_stb_i` in 1: Wishbone cycle and strobe. Request = `cyc & stb`.
- `wb_we_i` in 1: write enable.
- `wb_adr_i` in 32: byte address. Only `[7:2]` is decoded.
- `wb_sel_i` in 4: byte enables for writes.
- `wb_dat_i` in 32: write data.
- `wb_dat_o` out 32: registered read data.
- `wb_ack_o` out 1: registered acknowledge.
- `pwm_o` out NUM_CH: PWM outputs.
- `irq_o` out 1: level interrupt, `STATUS.WRAP & CTRL.IRQ_EN`.

## Operation
- Register map (byte offsets):
  - 0x00 CTRL, R/W: [0] EN, [1] IRQ_EN, [31:16] PRESCALE.
  - 0x04 PERIOD, R/W, CNT_W bits, shadow.
  - 0x08 STATUS: [0] WRAP, sticky; write 1 to clear.
  - 0x0C COUNT, read-only, current counter.
  - 0x10+4k DUTY[k], R/W, CNT_W bits, shadow, for k < NUM_CH.
- Field widths:
  - Writes honour `wb_sel_i` per byte and truncate to field width.
  - Reads zero-extend. Unused CTRL bits read 0.
- Unmapped accesses: reads return 0, writes are ignored, both are still acked.
- Reads of PERIOD/DUTY return the shadow value, not the active value.
- Prescaler `psc` (16 bits), with EN=1:
  - If `psc == PRESCALE`: `psc <= 0`, `tick = 1`.
  - Otherwise `psc <= psc + 1`.
- Counter `cnt` (CNT_W bits), on `tick`:
  - If `cnt == period_act`: `cnt <= 0`, set WRAP, copy all shadow registers to the active set.
  - Otherwise `cnt <= cnt + 1`.
- With EN=0:
  - `psc` and `cnt` are held at 0 and `pwm_o` is 0.
  - Active registers copy the shadows every cycle, so the first period after enable uses the latest values.
- Output: `pwm_o[k] <= EN & (cnt < duty_act[k])`, registered.
  - DUTY=0 gives constant low.
  - DUTY > PERIOD gives constant high.
- Resulting waveform: period = (PRESCALE+1)·(PERIOD+1) clocks; high time = min(DUTY, PERIOD+1)·(PRESCALE+1) clocks.
- Simultaneous events:
  - Wrap and a W1C write to STATUS in the same cycle: set wins, WRAP stays 1.
  - Shadow write and wrap in the same cycle: active takes the pre-write shadow value; the new value applies at the following wrap.
  - A write to CTRL clearing EN takes effect the next cycle, forcing `pwm_o` to 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - All registers go to 0, giving `pwm_o=0`, `irq_o=0`, `wb_ack_o=0`, `wb_dat_o=0`.
  - Asserting reset mid-period stops the output immediately.
- Bus handshake:
  - `wb_ack_o <= req & ~wb_ack_o`: ack rises one cycle after request and lasts exactly one cycle.
  - A held request yields an ack every other cycle.
  - A write commits on the edge that raises ack.
  - `wb_dat_o` is loaded on the same edge and is valid while ack is high.
- `pwm_o` lags `cnt` by one cycle.
- WRAP is set on the edge where `cnt` returns to 0; `irq_o` follows in the same cycle, since it is combinational from registers.
- COUNT read returns `cnt` as sampled at the request edge.

## Test plan
- **Reset:** hold `rst_ni=0` mid-run → all outputs 0 at once. Release → CTRL/PERIOD/DUTY read 0.
- **Basic PWM:** PRESCALE=0, PERIOD=9, DUTY0=3, DUTY1=0, DUTY2=12, EN=1 → `pwm_o[0]` high 3 of every 10 clocks, `pwm_o[1]` always 0, `pwm_o[2]` always 1. WRAP set every 10 clocks.
- **Prescaler:** PRESCALE=3, PERIOD=4, DUTY0=2 → period 20 clocks, high 8 clocks.
- **Shadow update:** change DUTY0 from 3 to 7 mid-period → current period still high 3 clocks, next period high 7. Readback of DUTY0 returns 7 immediately.
- **Interrupt, W1C and collision:** IRQ_EN=1 → `irq_o` rises at wrap. Write STATUS=1 → cleared. Repeat the write on the wrap cycle → WRAP remains 1.
- **Bus:** `wb_sel_i=4'b0001` write 0xAABBCCDD to PERIOD (CNT_W=16) → PERIOD reads 0x000000DD. Held stb → ack toggles 1,0,1. Read at 0xFC → 0, acked.

Source files
------------

// File: rtl/wb_pwm_bank.sv
// Wishbone-slave PWM bank: shared prescaler and period counter driving NUM_CH outputs.
// Period and duty registers are double-buffered and swap in only at period wrap.
module wb_pwm_bank #(
   parameter int NUM_CH = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wb_cyc_i,
   input  logic              wb_stb_i,
   input  logic              wb_we_i,
   input  logic [31:0]       wb_adr_i,
   input  logic [3:0]        wb_sel_i,
   input  logic [31:0]       wb_dat_i,
   output logic [31:0]       wb_dat_o,
   output logic              wb_ack_o,
   output logic [NUM_CH-1:0] pwm_o,
   output logic              irq_o
);

   localparam int DUTY_BASE = 4;

   logic              ack_q;
   logic [31:0]       dat_q;
   logic [31:0]       rd_data;
   logic              en_q;
   logic              irq_en_q;
   logic [15:0]       presc_q;
   logic [15:0]       psc_q;
   logic [CNT_W-1:0]  period_sh_q;
   logic [CNT_W-1:0]  period_act_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
   logic [CNT_W-1:0]  duty_act_q [NUM_CH];
   logic [NUM_CH-1:0] pwm_q;
   logic              wrap_q;
   logic              wrap_d;

   logic [5:0]  idx;
   logic        acc;
   logic        wr;
   logic        wr_ctrl;
   logic        wr_period;
   logic        wr_status;
   logic        clr_wrap;
   logic        tick;
   logic        wrap_evt;
   logic        load_act;
   logic [31:0] ctrl_wr;
   logic        unused_bits;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      res = old;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) res[8*b +: 8] = wdat[8*b +: 8];
      end
      return res;
   endfunction

   function automatic logic [CNT_W-1:0] merge_cnt(input logic [CNT_W-1:0] old,
                                                  input logic [31:0]      wdat,
                                                  input logic [3:0]       sel);
      logic [31:0] full;
      full = merge_bytes(32'(old), wdat, sel);
      return full[CNT_W-1:0];
   endfunction

   assign idx       = wb_adr_i[7:2];
   // An access is taken only on the edge that raises ack, so a held request acks every other cycle.
   assign acc       = wb_cyc_i & wb_stb_i & ~ack_q;
   assign wr        = acc & wb_we_i;
   assign wr_ctrl   = wr & (idx == 6'd0);
   assign wr_period = wr & (idx == 6'd1);
   assign wr_status = wr & (idx == 6'd2);
   assign clr_wrap  = wr_status & wb_sel_i[0] & wb_dat_i[0];
   assign ctrl_wr   = merge_bytes({presc_q, 14'b0, irq_en_q, en_q}, wb_dat_i, wb_sel_i);

   assign tick     = en_q & (psc_q == presc_q);
   assign wrap_evt = tick & (cnt_q == period_act_q);
   assign load_act = ~en_q | wrap_evt;
   // A wrap on the same edge as a W1C write keeps the flag set.
   assign wrap_d   = wrap_evt | (wrap_q & ~clr_wrap);

   assign unused_bits = ^{wb_adr_i[31:8], wb_adr_i[1:0], ctrl_wr[15:2]};

   always_comb begin
      rd_data = '0;
      case (idx)
         6'd0:    rd_data = {presc_q, 14'b0, irq_en_q, en_q};
         6'd1:    rd_data = 32'(period_sh_q);
         6'd2:    rd_data = {31'b0, wrap_q};
         6'd3:    rd_data = 32'(cnt_q);
         default: begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (idx == 6'(DUTY_BASE + k)) rd_data = 32'(duty_sh_q[k]);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= wb_cyc_i & wb_stb_i & ~ack_q;
         if (acc) dat_q <= rd_data;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q        <= 1'b0;
         irq_en_q    <= 1'b0;
         presc_q     <= '0;
         period_sh_q <= '0;
         wrap_q      <= 1'b0;
      end else begin
         if (wr_ctrl) begin
            en_q     <= ctrl_wr[0];
            irq_en_q <= ctrl_wr[1];
            presc_q  <= ctrl_wr[31:16];
         end
         if (wr_period) period_sh_q <= merge_cnt(period_sh_q, wb_dat_i, wb_sel_i);
         wrap_q <= wrap_d;
      end
   end

   // While disabled the counters idle at 0 and the active set tracks the shadows.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         psc_q        <= '0;
         cnt_q        <= '0;
         period_act_q <= '0;
      end else begin
         if (!en_q) begin
            psc_q <= '0;
            cnt_q <= '0;
         end else begin
            psc_q <= tick ? 16'd0 : psc_q + 16'd1;
            if (tick) cnt_q <= wrap_evt ? '0 : cnt_q + 1'b1;
         end
         if (load_act) period_act_q <= period_sh_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pwm_q <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            duty_sh_q[k]  <= '0;
            duty_act_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr && (idx == 6'(DUTY_BASE + k)))
               duty_sh_q[k] <= merge_cnt(duty_sh_q[k], wb_dat_i, wb_sel_i);
            if (load_act) duty_act_q[k] <= duty_sh_q[k];
            pwm_q[k] <= en_q & (cnt_q < duty_act_q[k]);
         end
      end
   end

   assign wb_ack_o = ack_q;
   assign wb_dat_o = dat_q;
   assign pwm_o    = pwm_q;
   assign irq_o    = wrap_q & irq_en_q;

endmodule

// File: tb/tb_wb_pwm_bank.sv
// Directed self-checking bench for wb_pwm_bank (NUM_CH=8, CNT_W=16).
// Bus tasks start and end just after a falling clock edge.
module tb_wb_pwm_bank;

   localparam int NUM_CH = 8;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b1;
   logic              cyc = 1'b0;
   logic              stb = 1'b0;
   logic              we = 1'b0;
   logic [31:0]       adr = '0;
   logic [31:0]       wdat = '0;
   logic [3:0]        sel = '0;
   logic [31:0]       dat_o;
   logic              ack_o;
   logic [NUM_CH-1:0] pwm_o;
   logic              irq_o;

   int n_chk = 0;
   int n_err = 0;

   wb_pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk_i    (clk),
      .rst_ni   (rst_ni),
      .wb_cyc_i (cyc),
      .wb_stb_i (stb),
      .wb_we_i  (we),
      .wb_adr_i (adr),
      .wb_sel_i (sel),
      .wb_dat_i (wdat),
      .wb_dat_o (dat_o),
      .wb_ack_o (ack_o),
      .pwm_o    (pwm_o),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd);
      logic got;
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      got = 1'b0;
      for (int i = 0; i < 4 && !got; i++) begin
         @(posedge clk); #1;
         if (ack_o) got = 1'b1;
      end
      rd = dat_o;
      if (!got) chk("ack_timeout", 32'd0, 32'd1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(negedge clk);
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] dummy;
      wb_xfer(1'b1, a, d, s, dummy);
   endtask

   task automatic wb_read(input logic [31:0] a, output logic [31:0] rd);
      wb_xfer(1'b0, a, 32'd0, 4'hF, rd);
   endtask

   task automatic wait_rise(input int k);
      logic prev;
      logic found;
      prev = pwm_o[k];
      found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (pwm_o[k] && !prev) found = 1'b1;
         prev = pwm_o[k];
      end
      if (!found) chk("rise_timeout", 32'd0, 32'd1);
   endtask

   task automatic measure(input int k, output int per, output int hi);
      logic prev;
      logic found;
      wait_rise(k);
      per = 1; hi = 1; prev = 1'b1; found = 1'b0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (pwm_o[k] && !prev) found = 1'b1;
         else begin
            per++;
            if (pwm_o[k]) hi++;
         end
         prev = pwm_o[k];
      end
      if (!found) chk("period_timeout", 32'd0, 32'd1);
   endtask

   task automatic count_hi(input int k, input int ncyc, output int hi);
      hi = 0;
      for (int n = 0; n < ncyc; n++) begin
         @(negedge clk);
         if (pwm_o[k]) hi++;
      end
   endtask

   task automatic count_run(input int k, output int run);
      logic done;
      run = 1; done = 1'b0;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge clk);
         if (pwm_o[k]) run++;
         else done = 1'b1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int per, hi, run;
      logic found;

      // reset state
      #2 rst_ni = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pwm", 32'(pwm_o), 32'd0);
      chk("rst_irq", 32'(irq_o), 32'd0);
      chk("rst_ack", 32'(ack_o), 32'd0);
      chk("rst_dat", dat_o, 32'd0);
      rst_ni = 1'b1;
      @(negedge clk);
      wb_read(32'h00, rd); chk("rst_ctrl", rd, 32'd0);
      wb_read(32'h04, rd); chk("rst_period", rd, 32'd0);
      wb_read(32'h10, rd); chk("rst_duty0", rd, 32'd0);

      // basic PWM, PRESCALE=0, PERIOD=9
      wb_write(32'h04, 32'd9, 4'hF);
      wb_write(32'h10, 32'd3, 4'hF);
      wb_write(32'h14, 32'd0, 4'hF);
      wb_write(32'h18, 32'd12, 4'hF);
      wb_write(32'h00, 32'h1, 4'hF);
      wb_read(32'h0C, rd); chk("count_after_en", rd, 32'd1);
      measure(0, per, hi);
      chk("basic_period", 32'(per), 32'd10);
      chk("basic_high", 32'(hi), 32'd3);
      count_hi(1, 30, hi); chk("duty0_low", 32'(hi), 32'd0);
      count_hi(2, 30, hi); chk("duty_gt_period_high", 32'(hi), 32'd30);
      wb_read(32'h08, rd); chk("wrap_set", rd, 32'd1);

      // shadow update mid-period
      wait_rise(0);
      fork
         wb_write(32'h10, 32'd7, 4'hF);
         count_run(0, run);
      join
      chk("shadow_cur_high", 32'(run), 32'd3);
      wb_read(32'h10, rd); chk("shadow_readback", rd, 32'd7);
      measure(0, per, hi);
      chk("shadow_next_period", 32'(per), 32'd10);
      chk("shadow_next_high", 32'(hi), 32'd7);

      // interrupt, W1C, collision
      wb_write(32'h00, 32'h3, 4'hF);
      chk("irq_level", 32'(irq_o), 32'd1);
      wait_rise(0);
      wb_write(32'h08, 32'h1, 4'h1);
      wb_read(32'h08, rd); chk("w1c_clear", rd, 32'd0);
      chk("irq_cleared", 32'(irq_o), 32'd0);
      found = 1'b0;
      for (int n = 0; n < 30 && !found; n++) begin
         @(negedge clk);
         if (irq_o) found = 1'b1;
      end
      chk("irq_rise", 32'(found), 32'd1);
      chk("pwm_at_wrap", 32'(pwm_o[0]), 32'd0);
      @(negedge clk);
      chk("pwm_after_wrap", 32'(pwm_o[0]), 32'd1);
      repeat (8) @(negedge clk);
      wb_write(32'h08, 32'h1, 4'h1);
      wb_read(32'h08, rd); chk("w1c_collision", rd, 32'd1);
      chk("irq_collision", 32'(irq_o), 32'd1);

      // disable, then prescaler
      wb_write(32'h00, 32'h0, 4'hF);
      chk("en_clear_pwm", 32'(pwm_o), 32'd0);
      wb_read(32'h0C, rd); chk("count_disabled", rd, 32'd0);
      wb_write(32'h08, 32'h1, 4'h1);
      wb_read(32'h08, rd); chk("status_disabled", rd, 32'd0);
      wb_write(32'h04, 32'd4, 4'hF);
      wb_write(32'h10, 32'd2, 4'hF);
      wb_write(32'h00, 32'h0003_0001, 4'hF);
      measure(0, per, hi);
      chk("psc_period", 32'(per), 32'd20);
      chk("psc_high", 32'(hi), 32'd8);

      // bus: byte enables, truncation, unmapped, held strobe
      wb_write(32'h00, 32'h0, 4'hF);
      wb_write(32'h04, 32'hAABB_CCDD, 4'b0001);
      wb_read(32'h04, rd); chk("sel_byte0", rd, 32'h0000_00DD);
      wb_write(32'h04, 32'h1122_3344, 4'b0010);
      wb_read(32'h04, rd); chk("sel_byte1", rd, 32'h0000_33DD);
      wb_write(32'h14, 32'hAABB_CCDD, 4'hF);
      wb_read(32'h14, rd); chk("duty_trunc", rd, 32'h0000_CCDD);
      wb_write(32'h00, 32'hFFFF_FFFF, 4'b1100);
      wb_read(32'h00, rd); chk("ctrl_upper", rd, 32'hFFFF_0000);
      wb_write(32'h40, 32'hFFFF_FFFF, 4'hF);
      wb_read(32'h40, rd); chk("unmapped_rd", rd, 32'd0);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hFC; sel = 4'hF;
      @(negedge clk); chk("held_ack1", 32'(ack_o), 32'd1);
      chk("held_dat", dat_o, 32'd0);
      @(negedge clk); chk("held_ack2", 32'(ack_o), 32'd0);
      @(negedge clk); chk("held_ack3", 32'(ack_o), 32'd1);
      cyc = 1'b0; stb = 1'b0;
      @(negedge clk);

      // reset mid-run
      wb_write(32'h04, 32'd9, 4'hF);
      wb_write(32'h10, 32'd3, 4'hF);
      wb_write(32'h00, 32'h3, 4'hF);
      wait_rise(0);
      chk("irq_pre_rst", 32'(irq_o), 32'd1);
      #2 rst_ni = 1'b0;
      #1;
      chk("midrst_pwm", 32'(pwm_o), 32'd0);
      chk("midrst_irq", 32'(irq_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      wb_read(32'h00, rd); chk("midrst_ctrl", rd, 32'd0);
      wb_read(32'h04, rd); chk("midrst_period", rd, 32'd0);
      wb_read(32'h10, rd); chk("midrst_duty0", rd, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
